rf_wb_arbiter: RTL and testbench
================================

// Module: rf_wb_arbiter
// PURPOSE
//  Shares the register file's single write port (we3/a3/wd3) between two writers:
//   - the in-order pipeline writeback stage;
//   - a long-latency unit (LLU: mul/div/uncached load) that completes out of band.
//  Buffers LLU results and forces a one-cycle pipeline hold when the LLU starves.
//  Keeps a register busy scoreboard so issue stalls on RAW/WAW against in-flight LLU ops.
// PARAMETERS
//  DEPTH         2   LLU result FIFO entries (>=1)
//  STARVE_LIMIT  4   consecutive unserved cycles with FIFO non-empty before FORCE (>=1)
//  XLEN          32  data width
// PORTS
//  clk        in   1     clock; all state updates on posedge
//  reset      in   1     asynchronous, active-high reset
//  wb_valid   in   1     pipeline writeback valid this cycle
//  wb_rd      in   5     pipeline destination register
//  wb_data    in   XLEN  pipeline writeback data
//  wb_hold    out  1     pipeline must stall WB this cycle and re-present it next cycle
//  llu_valid  in   1     LLU result valid
//  llu_rd     in   5     LLU destination register
//  llu_data   in   XLEN  LLU result data
//  llu_ready  out  1     FIFO accepts LLU result (count < DEPTH)
//  iss_valid  in   1     decode stage issuing an instruction
//  iss_llu    in   1     issued instruction executes on the LLU
//  iss_rs1    in   5     source 1
//  iss_rs2    in   5     source 2
//  iss_rd     in   5     destination
//  iss_stall  out  1     hazard against busy register; hold issue
//  rf_we      out  1     to regfile we3
//  rf_a3      out  5     to regfile a3
//  rf_wd3     out  XLEN  to regfile wd3
//  busy       out  32    scoreboard; bit n = LLU write to xn pending
// BEHAVIOUR
//  Reset (async, while high):
//   - FIFO emptied, busy=0, starve counter=0, FSM=IDLE.
//   - Outputs: rf_we=0, wb_hold=0, iss_stall=0, llu_ready=1.
//   - Reset mid-operation drops buffered results; no write is issued.
//  x0:
//   - A write with rd=0 never raises rf_we and does not consume the port.
//   - iss_rd=0 never sets busy; rs=0 or rd=0 never causes a hazard.
//  FIFO:
//   - Push on llu_valid && llu_ready.
//   - llu_ready = count < DEPTH, computed from registered count.
//   - When full, no push even if a pop occurs the same cycle.
//  Port grant (combinational, zero latency; rf_* driven from the winner):
//   - FSM==FORCE: FIFO head wins; wb_hold=1; wb_valid ignored.
//   - else wb_valid && wb_rd!=0: pipeline wins.
//   - else FIFO non-empty: FIFO head wins (pop).
//   - else rf_we=0; rf_a3/rf_wd3 hold last value.
//  FSM (registered), states IDLE / WAIT / FORCE:
//   - IDLE: FIFO empty, counter=0. A push -> WAIT.
//   - WAIT, pop this cycle: counter := 0. Stay in WAIT if entries remain, else -> IDLE.
//   - WAIT, no pop: counter++. At STARVE_LIMIT-1 with no pop -> FORCE; counter := 0.
//   - FORCE: exactly one cycle; pops head.
//     -> WAIT if entries remain (counter restarts from 0), else -> IDLE.
//   - wb_hold is asserted only in FORCE.
//  Scoreboard:
//   - iss_stall = iss_valid && (busy[rs1] || busy[rs2] || busy[rd]) for non-zero indices.
//   - Uses registered busy; no same-cycle bypass of a clear.
//   - Set busy[iss_rd] at posedge when iss_valid && iss_llu && !iss_stall && iss_rd!=0.
//   - Clear busy[head.rd] at posedge of a FIFO pop.
//   - Set and clear of the same bit cannot coincide: a set requires busy=0.
//  LLU contract: llu_rd always names a register the scoreboard marked busy.
// TESTING
//  1. Fill FIFO (2 entries), assert reset mid-stream -> busy=0, llu_ready=1, rf_we=0; no write after release.
//  2. wb_valid=1, rd=5, data=32'h1234, FIFO empty -> same cycle rf_we=1, rf_a3=5, rf_wd3=32'h1234, wb_hold=0.
//  3. Issue iss_llu with rd=7 -> busy[7]=1; issue rs1=7 -> iss_stall=1.
//     LLU returns 32'hdead with pipeline idle -> next cycle rf_we=1, a3=7; busy[7]=0 after that edge; stall drops.
//  4. STARVE_LIMIT=4, wb_valid continuous, one LLU push for rd=9
//     -> 4 cycles of pipeline wins, then 1 cycle wb_hold=1 with rf_a3=9; FSM returns to IDLE.
//  5. wb_valid continuous, LLU pushes 3 results -> llu_ready=0 after the 2nd; 3rd accepted only after a pop.
//     wb_rd=0 cycle -> FIFO head takes the port.
//  6. iss_llu with rd=0 -> busy unchanged. Issue rd=7 while busy[7]=1 (WAW) -> iss_stall=1, no set.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter
//
// Shares the register file's single write port (we3/a3/wd3) between the
// in-order pipeline writeback stage and a long-latency unit (LLU: mul, div,
// uncached load) that completes out of band.
//
// LLU results are buffered in a small FIFO. The pipeline normally wins the
// port. The FIFO drains whenever the pipeline leaves the port free. If the
// FIFO head goes unserved for STARVE_LIMIT consecutive cycles, the block
// forces a one-cycle pipeline hold so that the head can retire.
//
// A 32-bit busy scoreboard tracks registers with an LLU write in flight.
// Issue stalls on RAW/WAW hazards against those registers.
//
// Parameters
//   DEPTH         LLU result FIFO entries (>= 1)
//   STARVE_LIMIT  consecutive unserved cycles before a forced drain (>= 1)
//   XLEN          data width
//
// Ports
//   clk, reset              clock; asynchronous active-high reset
//   wb_valid/wb_rd/wb_data  pipeline writeback request
//   wb_hold                 pipeline must stall WB and re-present it next cycle
//   llu_valid/llu_rd/...    LLU result; llu_ready = FIFO has room
//   iss_*                   decode-stage issue; iss_stall = hazard, hold issue
//   rf_we/rf_a3/rf_wd3      register file write port
//   busy                    scoreboard, bit n = LLU write to xn pending
// -----------------------------------------------------------------------------
module rf_wb_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4,
    parameter int XLEN         = 32
) (
    input  logic            clk,
    input  logic            reset,
    // pipeline writeback
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            wb_hold,
    // long-latency unit results
    input  logic            llu_valid,
    input  logic [4:0]      llu_rd,
    input  logic [XLEN-1:0] llu_data,
    output logic            llu_ready,
    // issue-side hazard check
    input  logic            iss_valid,
    input  logic            iss_llu,
    input  logic [4:0]      iss_rs1,
    input  logic [4:0]      iss_rs2,
    input  logic [4:0]      iss_rd,
    output logic            iss_stall,
    // register file write port
    output logic            rf_we,
    output logic [4:0]      rf_a3,
    output logic [XLEN-1:0] rf_wd3,
    // scoreboard
    output logic [31:0]     busy
);

    // -------------------------------------------------------------------------
    // Sizing
    // -------------------------------------------------------------------------
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;

    localparam logic [CW-1:0] FULL_COUNT  = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_SLOT   = PW'(DEPTH - 1);
    localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_LIMIT - 1);

    // Starvation FSM encoding
    localparam logic [1:0] S_IDLE  = 2'd0;  // FIFO empty
    localparam logic [1:0] S_WAIT  = 2'd1;  // FIFO holds entries, counting starvation
    localparam logic [1:0] S_FORCE = 2'd2;  // one-cycle forced drain of the head

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } entry_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    entry_t          mem [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [SW-1:0]   starve;
    logic [SW-1:0]   starve_nxt;

    logic [31:0]     busy_q;
    logic [4:0]      last_a3;
    logic [XLEN-1:0] last_wd3;

    // -------------------------------------------------------------------------
    // Combinational datapath
    // -------------------------------------------------------------------------
    entry_t          head_e;
    logic            fifo_nonempty;
    logic            push;
    logic            pop;
    logic            pipe_req;
    logic            grant;
    logic [4:0]      win_rd;
    logic [XLEN-1:0] win_data;
    logic            hit_rs1;
    logic            hit_rs2;
    logic            hit_rd;
    logic [31:0]     set_mask;
    logic [31:0]     clr_mask;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_SLOT) ? '0 : p + PW'(1);
    endfunction

    assign head_e        = mem[head];
    assign fifo_nonempty = (count != '0);

    // Readiness comes from the registered count only. A pop in the same
    // cycle therefore never frees a slot for a push into a full FIFO.
    assign llu_ready = (count < FULL_COUNT);
    assign push      = llu_valid && llu_ready;

    // A pipeline write to x0 does not compete for the port.
    assign pipe_req  = wb_valid && (wb_rd != 5'd0);

    // Port grant priority: forced drain, then pipeline, then FIFO head.
    // With no winner, a3/wd3 keep the last value driven.
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/case can leave it unassigned and infer a latch.
    always_comb begin
        pop      = 1'b0;
        grant    = 1'b0;
        win_rd   = last_a3;
        win_data = last_wd3;
        if (state == S_FORCE) begin
            pop      = 1'b1;
            grant    = (head_e.rd != 5'd0);
            win_rd   = head_e.rd;
            win_data = head_e.data;
        end else if (pipe_req) begin
            grant    = 1'b1;
            win_rd   = wb_rd;
            win_data = wb_data;
        end else if (fifo_nonempty) begin
            pop      = 1'b1;
            grant    = (head_e.rd != 5'd0);
            win_rd   = head_e.rd;
            win_data = head_e.data;
        end
    end

    // While reset is high the port is kept quiet even if the pipeline
    // presents a write.
    assign rf_we   = grant && !reset;
    assign rf_a3   = win_rd;
    assign rf_wd3  = win_data;
    assign wb_hold = (state == S_FORCE);

    // -------------------------------------------------------------------------
    // Scoreboard
    // -------------------------------------------------------------------------
    // Hazards use the registered busy vector. A register cleared by this
    // cycle's pop still stalls until the next cycle.
    assign hit_rs1   = (iss_rs1 != 5'd0) && busy_q[iss_rs1];
    assign hit_rs2   = (iss_rs2 != 5'd0) && busy_q[iss_rs2];
    assign hit_rd    = (iss_rd  != 5'd0) && busy_q[iss_rd];
    assign iss_stall = iss_valid && (hit_rs1 || hit_rs2 || hit_rd);

    // A set needs busy[rd]=0 (else WAW stall). It can therefore never collide
    // with the clear of the same bit, which needs busy[rd]=1.
    assign set_mask = (iss_valid && iss_llu && !iss_stall && (iss_rd != 5'd0))
                      ? (32'd1 << iss_rd) : 32'd0;
    assign clr_mask = (pop && (head_e.rd != 5'd0))
                      ? (32'd1 << head_e.rd) : 32'd0;

    assign busy = busy_q;

    // -------------------------------------------------------------------------
    // Starvation FSM next-state
    // -------------------------------------------------------------------------
    always_comb begin
        unique case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_comb begin
        state_nxt  = state;
        starve_nxt = starve;
        case (state)
            S_IDLE: begin
                starve_nxt = '0;
                if (push) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (pop) begin
                    starve_nxt = '0;
                    state_nxt  = (count_nxt != '0) ? S_WAIT : S_IDLE;
                end else if (starve == STARVE_LAST) begin
                    // STARVE_LIMIT unserved cycles so far: force the next one
                    starve_nxt = '0;
                    state_nxt  = S_FORCE;
                end else begin
                    starve_nxt = starve + SW'(1);
                end
            end
            S_FORCE: begin
                // The head always pops here; the FORCE state lasts one cycle.
                starve_nxt = '0;
                state_nxt  = (count_nxt != '0) ? S_WAIT : S_IDLE;
            end
            default: begin
                starve_nxt = '0;
                state_nxt  = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Sequential state
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. All flops
    // then sample pre-edge values, whatever order the blocks run in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            state  <= S_IDLE;
            starve <= '0;
            busy_q <= '0;
        end else begin
            if (push) begin
                tail <= next_ptr(tail);
            end
            if (pop) begin
                head <= next_ptr(head);
            end
            count  <= count_nxt;
            state  <= state_nxt;
            starve <= starve_nxt;
            busy_q <= (busy_q & ~clr_mask) | set_mask;
        end
    end

    // NOTE: FIFO storage has no reset. The pointers and count make stale
    // slots unreachable, so clearing the data would only add reset fanout.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= '{rd: llu_rd, data: llu_data};
        end
    end

    // Last value driven on a3/wd3, held while the port is idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_a3  <= '0;
            last_wd3 <= '0;
        end else if (grant) begin
            last_a3  <= win_rd;
            last_wd3 <= win_data;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_wb_arbiter
//
// Self-checking bench for rf_wb_arbiter. A behavioural model (result queue,
// busy bit array, count of consecutive unserved cycles) predicts each cycle's
// port grant, hold, stall and scoreboard state. Directed scenario tasks and a
// randomized run compare the DUT against it and against literal values.
// -----------------------------------------------------------------------------
module tb_rf_wb_arbiter;

    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 4;
    localparam int XLEN         = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            wb_hold;
    logic            llu_valid;
    logic [4:0]      llu_rd;
    logic [XLEN-1:0] llu_data;
    logic            llu_ready;
    logic            iss_valid;
    logic            iss_llu;
    logic [4:0]      iss_rs1;
    logic [4:0]      iss_rs2;
    logic [4:0]      iss_rd;
    logic            iss_stall;
    logic            rf_we;
    logic [4:0]      rf_a3;
    logic [XLEN-1:0] rf_wd3;
    logic [31:0]     busy;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT), .XLEN(XLEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .wb_hold   (wb_hold),
        .llu_valid (llu_valid),
        .llu_rd    (llu_rd),
        .llu_data  (llu_data),
        .llu_ready (llu_ready),
        .iss_valid (iss_valid),
        .iss_llu   (iss_llu),
        .iss_rs1   (iss_rs1),
        .iss_rs2   (iss_rs2),
        .iss_rd    (iss_rd),
        .iss_stall (iss_stall),
        .rf_we     (rf_we),
        .rf_a3     (rf_a3),
        .rf_wd3    (rf_wd3),
        .busy      (busy)
    );

    int vectors     = 0;
    int miscompares = 0;

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];      // buffered LLU results, oldest first
    logic [4:0]  outst[$];   // LLU ops issued but not yet returned
    logic [31:0] m_busy;
    int          m_unserved; // consecutive cycles the head went unserved
    bit          m_force;
    logic [4:0]  m_last_a3;
    logic [31:0] m_last_wd;
    bit          m_last_ok;

    // per-cycle predictions
    bit          e_we, e_hold, e_stall, e_ready, e_pop, e_known, e_issue;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;
    int          e_size;

    task automatic model_clear();
        mq.delete();
        outst.delete();
        m_busy     = '0;
        m_unserved = 0;
        m_force    = 1'b0;
        m_last_a3  = '0;
        m_last_wd  = '0;
        m_last_ok  = 1'b0;
    endtask

    task automatic model_eval();
        e_size  = mq.size();
        e_hold  = m_force;
        e_pop   = 1'b0;
        e_we    = 1'b0;
        e_a3    = m_last_a3;
        e_wd    = m_last_wd;
        e_known = m_last_ok;
        if (m_force || (!(wb_valid && wb_rd != 0) && e_size > 0)) begin
            e_pop   = 1'b1;
            e_a3    = mq[0].rd;
            e_wd    = mq[0].data;
            e_we    = (mq[0].rd != 0);
            e_known = 1'b1;
        end else if (wb_valid && wb_rd != 0) begin
            e_we    = 1'b1;
            e_a3    = wb_rd;
            e_wd    = wb_data;
            e_known = 1'b1;
        end
        e_stall = iss_valid && ((iss_rs1 != 0 && m_busy[iss_rs1]) ||
                                (iss_rs2 != 0 && m_busy[iss_rs2]) ||
                                (iss_rd  != 0 && m_busy[iss_rd]));
        e_ready = (e_size < DEPTH);
        e_issue = iss_valid && iss_llu && !e_stall && (iss_rd != 0);
    endtask

    task automatic model_update();
        ent_t e;
        if (e_pop) begin
            if (mq[0].rd != 0) m_busy[mq[0].rd] = 1'b0;
            void'(mq.pop_front());
        end
        if (llu_valid && e_ready) begin
            e.rd   = llu_rd;
            e.data = llu_data;
            mq.push_back(e);
            for (int i = 0; i < outst.size(); i++) begin
                if (outst[i] == llu_rd) begin
                    outst.delete(i);
                    break;
                end
            end
        end
        if (e_issue) begin
            m_busy[iss_rd] = 1'b1;
            outst.push_back(iss_rd);
        end
        if (e_we) begin
            m_last_a3 = e_a3;
            m_last_wd = e_wd;
            m_last_ok = 1'b1;
        end
        if (e_pop) begin
            m_unserved = 0;
            m_force    = 1'b0;
        end else if (e_size > 0) begin
            m_unserved++;
            if (m_unserved == STARVE_LIMIT) begin
                m_force    = 1'b1;
                m_unserved = 0;
            end
        end else begin
            m_unserved = 0;
            m_force    = 1'b0;
        end
    endtask

    // ------------------------------------------------------------------------
    // Cycle helpers: inputs change at posedge+1, outputs sampled at negedge
    // ------------------------------------------------------------------------
    task automatic settle();
        #4;
        model_eval();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_idle();
        wb_valid  = 1'b0;
        wb_rd     = '0;
        wb_data   = '0;
        llu_valid = 1'b0;
        llu_rd    = '0;
        llu_data  = '0;
        iss_valid = 1'b0;
        iss_llu   = 1'b0;
        iss_rs1   = '0;
        iss_rs2   = '0;
        iss_rd    = '0;
    endtask

    task automatic release_reset();
        set_idle();
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        set_idle();
        reset = 1'b1;
        @(posedge clk);
        #2;
        release_reset();
    endtask

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset();
        set_idle();
        wb_valid = 1'b1;
        wb_rd    = 5'd1;
        wb_data  = 32'h5a5a_0001;
        reset    = 1'b1;
        #3;
        vectors++; if (rf_we !== 1'b0)     begin miscompares++; $display("FAIL reset_rf_we: got %b want 0", rf_we); end
        vectors++; if (wb_hold !== 1'b0)   begin miscompares++; $display("FAIL reset_wb_hold: got %b want 0", wb_hold); end
        vectors++; if (iss_stall !== 1'b0) begin miscompares++; $display("FAIL reset_iss_stall: got %b want 0", iss_stall); end
        vectors++; if (llu_ready !== 1'b1) begin miscompares++; $display("FAIL reset_llu_ready: got %b want 1", llu_ready); end
        vectors++; if (busy !== 32'h0)     begin miscompares++; $display("FAIL reset_busy: got %h want 0", busy); end
        release_reset();

        // fill the FIFO with two results while the pipeline owns the port
        iss_valid = 1'b1; iss_llu = 1'b1; iss_rd = 5'd3;
        settle(); advance();
        iss_rd = 5'd4;
        settle(); advance();
        iss_valid = 1'b0; iss_llu = 1'b0; iss_rd = '0;
        wb_valid = 1'b1; wb_rd = 5'd2; wb_data = $urandom;
        llu_valid = 1'b1; llu_rd = 5'd3; llu_data = $urandom;
        settle(); advance();
        llu_rd = 5'd4; llu_data = $urandom;
        settle(); advance();
        llu_valid = 1'b0;
        settle();
        vectors++; if (llu_ready !== 1'b0) begin miscompares++; $display("FAIL fill_llu_ready: got %b want 0", llu_ready); end
        vectors++; if (busy !== 32'h18)    begin miscompares++; $display("FAIL fill_busy: got %h want 18", busy); end

        // reset mid-stream, pipeline still requesting
        reset = 1'b1;
        #2;
        vectors++; if (busy !== 32'h0)     begin miscompares++; $display("FAIL midrst_busy: got %h want 0", busy); end
        vectors++; if (llu_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_llu_ready: got %b want 1", llu_ready); end
        vectors++; if (rf_we !== 1'b0)     begin miscompares++; $display("FAIL midrst_rf_we: got %b want 0", rf_we); end
        @(posedge clk);
        release_reset();
        for (int i = 0; i < 6; i++) begin
            settle();
            vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL post_rst_no_write[%0d]: got %b want 0", i, rf_we); end
            advance();
        end
    endtask

    task automatic test_wb_write();
        apply_reset();
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234;
        settle();
        vectors++; if (rf_we !== 1'b1)      begin miscompares++; $display("FAIL wb_rf_we: got %b want 1", rf_we); end
        vectors++; if (rf_a3 !== 5'd5)      begin miscompares++; $display("FAIL wb_rf_a3: got %0d want 5", rf_a3); end
        vectors++; if (rf_wd3 !== 32'h1234) begin miscompares++; $display("FAIL wb_rf_wd3: got %h want 1234", rf_wd3); end
        vectors++; if (wb_hold !== 1'b0)    begin miscompares++; $display("FAIL wb_hold: got %b want 0", wb_hold); end
        advance();
        wb_rd = 5'd0;
        settle();
        vectors++; if (rf_we !== 1'b0)      begin miscompares++; $display("FAIL wb_x0_rf_we: got %b want 0", rf_we); end
        advance();
        set_idle();
    endtask

    task automatic test_scoreboard();
        apply_reset();
        iss_valid = 1'b1; iss_llu = 1'b1; iss_rd = 5'd7;
        settle();
        vectors++; if (iss_stall !== 1'b0) begin miscompares++; $display("FAIL sb_issue_stall: got %b want 0", iss_stall); end
        advance();
        iss_llu = 1'b0; iss_rd = 5'd1; iss_rs1 = 5'd7;
        settle();
        vectors++; if (busy[7] !== 1'b1)   begin miscompares++; $display("FAIL sb_busy7_set: got %b want 1", busy[7]); end
        vectors++; if (iss_stall !== 1'b1) begin miscompares++; $display("FAIL sb_raw_stall: got %b want 1", iss_stall); end
        advance();
        llu_valid = 1'b1; llu_rd = 5'd7; llu_data = 32'hdead;
        settle();
        vectors++; if (rf_we !== 1'b0)     begin miscompares++; $display("FAIL sb_push_cycle_we: got %b want 0", rf_we); end
        advance();
        llu_valid = 1'b0;
        settle();
        vectors++; if (rf_we !== 1'b1)      begin miscompares++; $display("FAIL sb_drain_we: got %b want 1", rf_we); end
        vectors++; if (rf_a3 !== 5'd7)      begin miscompares++; $display("FAIL sb_drain_a3: got %0d want 7", rf_a3); end
        vectors++; if (rf_wd3 !== 32'hdead) begin miscompares++; $display("FAIL sb_drain_wd3: got %h want dead", rf_wd3); end
        vectors++; if (iss_stall !== 1'b1)  begin miscompares++; $display("FAIL sb_no_bypass: got %b want 1", iss_stall); end
        advance();
        settle();
        vectors++; if (busy[7] !== 1'b0)   begin miscompares++; $display("FAIL sb_busy7_clear: got %b want 0", busy[7]); end
        vectors++; if (iss_stall !== 1'b0) begin miscompares++; $display("FAIL sb_stall_drop: got %b want 0", iss_stall); end
        advance();
        set_idle();
    endtask

    task automatic test_starvation();
        logic [31:0] d9;
        apply_reset();
        iss_valid = 1'b1; iss_llu = 1'b1; iss_rd = 5'd9;
        settle(); advance();
        iss_valid = 1'b0; iss_llu = 1'b0; iss_rd = '0;
        d9 = $urandom;
        wb_valid = 1'b1; wb_rd = 5'($urandom_range(1, 31)); wb_data = $urandom;
        llu_valid = 1'b1; llu_rd = 5'd9; llu_data = d9;
        settle(); advance();
        llu_valid = 1'b0;
        for (int k = 0; k < STARVE_LIMIT; k++) begin
            wb_rd = 5'($urandom_range(1, 31)); wb_data = $urandom;
            settle();
            vectors++; if (wb_hold !== 1'b0) begin miscompares++; $display("FAIL starve_hold[%0d]: got %b want 0", k, wb_hold); end
            vectors++; if (rf_a3 !== wb_rd)  begin miscompares++; $display("FAIL starve_pipe_a3[%0d]: got %0d want %0d", k, rf_a3, wb_rd); end
            advance();
        end
        wb_rd = 5'($urandom_range(1, 31)); wb_data = $urandom;
        settle();
        vectors++; if (wb_hold !== 1'b1) begin miscompares++; $display("FAIL force_hold: got %b want 1", wb_hold); end
        vectors++; if (rf_we !== 1'b1)   begin miscompares++; $display("FAIL force_we: got %b want 1", rf_we); end
        vectors++; if (rf_a3 !== 5'd9)   begin miscompares++; $display("FAIL force_a3: got %0d want 9", rf_a3); end
        vectors++; if (rf_wd3 !== d9)    begin miscompares++; $display("FAIL force_wd3: got %h want %h", rf_wd3, d9); end
        advance();
        for (int k = 0; k < 3; k++) begin
            wb_rd = 5'($urandom_range(1, 31)); wb_data = $urandom;
            settle();
            vectors++; if (wb_hold !== 1'b0) begin miscompares++; $display("FAIL post_force_hold[%0d]: got %b want 0", k, wb_hold); end
            vectors++; if (rf_a3 !== wb_rd)  begin miscompares++; $display("FAIL post_force_a3[%0d]: got %0d want %0d", k, rf_a3, wb_rd); end
            vectors++; if (busy !== 32'h0)   begin miscompares++; $display("FAIL post_force_busy[%0d]: got %h want 0", k, busy); end
            advance();
        end
        set_idle();
    endtask

    task automatic test_fifo_full();
        bit accepted;
        apply_reset();
        for (int r = 10; r <= 12; r++) begin
            iss_valid = 1'b1; iss_llu = 1'b1; iss_rd = 5'(r);
            settle(); advance();
        end
        set_idle();
        wb_valid = 1'b1;
        for (int r = 10; r <= 11; r++) begin
            wb_rd = 5'($urandom_range(1, 31)); wb_data = $urandom;
            llu_valid = 1'b1; llu_rd = 5'(r); llu_data = $urandom;
            settle(); advance();
        end
        llu_rd = 5'd12; llu_data = 32'hc0de_0012;
        wb_rd = 5'($urandom_range(1, 31)); wb_data = $urandom;
        settle();
        vectors++; if (llu_ready !== 1'b0) begin miscompares++; $display("FAIL full_llu_ready: got %b want 0", llu_ready); end
        accepted = 1'b0;
        for (int c = 0; c < 20 && !accepted; c++) begin
            if (c > 0) settle();
            vectors++; if (llu_ready !== e_ready) begin miscompares++; $display("FAIL full_wait_ready[%0d]: got %b want %b", c, llu_ready, e_ready); end
            vectors++; if (wb_hold !== e_hold)    begin miscompares++; $display("FAIL full_wait_hold[%0d]: got %b want %b", c, wb_hold, e_hold); end
            accepted = e_ready;
            advance();
            wb_rd = 5'($urandom_range(1, 31)); wb_data = $urandom;
        end
        vectors++; if (!accepted) begin miscompares++; $display("FAIL full_third_accept: got timeout want accept"); end
        llu_valid = 1'b0;
        wb_rd = 5'd0;
        settle();
        vectors++; if (rf_we !== 1'b1) begin miscompares++; $display("FAIL x0_head_we: got %b want 1", rf_we); end
        vectors++; if (rf_a3 !== e_a3) begin miscompares++; $display("FAIL x0_head_a3: got %0d want %0d", rf_a3, e_a3); end
        advance();
        set_idle();
        for (int c = 0; c < 6; c++) begin
            settle();
            vectors++; if (rf_we !== e_we) begin miscompares++; $display("FAIL full_drain_we[%0d]: got %b want %b", c, rf_we, e_we); end
            advance();
        end
        settle();
        vectors++; if (busy !== 32'h0) begin miscompares++; $display("FAIL full_drain_busy: got %h want 0", busy); end
        advance();
    endtask

    task automatic test_x0_waw();
        apply_reset();
        iss_valid = 1'b1; iss_llu = 1'b1; iss_rd = 5'd0; iss_rs1 = 5'd0; iss_rs2 = 5'd0;
        settle();
        vectors++; if (iss_stall !== 1'b0) begin miscompares++; $display("FAIL x0_issue_stall: got %b want 0", iss_stall); end
        advance();
        iss_rd = 5'd7;
        settle();
        vectors++; if (busy !== 32'h0) begin miscompares++; $display("FAIL x0_busy: got %h want 0", busy); end
        advance();
        settle();
        vectors++; if (iss_stall !== 1'b1) begin miscompares++; $display("FAIL waw_stall: got %b want 1", iss_stall); end
        advance();
        iss_valid = 1'b0;
        settle();
        vectors++; if (busy !== 32'h80) begin miscompares++; $display("FAIL waw_busy: got %h want 80", busy); end
        advance();
        llu_valid = 1'b1; llu_rd = 5'd7; llu_data = $urandom;
        settle(); advance();
        set_idle();
        settle(); advance();
        settle();
        vectors++; if (busy !== 32'h0) begin miscompares++; $display("FAIL waw_clean_busy: got %h want 0", busy); end
        advance();
    endtask

    task automatic test_random();
        apply_reset();
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) apply_reset();
            wb_valid  = ($urandom_range(0, 9) < 6);
            wb_rd     = 5'($urandom_range(0, 31));
            wb_data   = $urandom;
            iss_valid = $urandom_range(0, 1);
            iss_llu   = $urandom_range(0, 1);
            iss_rs1   = 5'($urandom_range(0, 15));
            iss_rs2   = 5'($urandom_range(0, 15));
            iss_rd    = 5'($urandom_range(0, 15));
            llu_valid = 1'b0;
            llu_rd    = '0;
            llu_data  = $urandom;
            if (outst.size() > 0 && $urandom_range(0, 2) == 0) begin
                llu_valid = 1'b1;
                llu_rd    = outst[$urandom_range(0, outst.size() - 1)];
            end
            settle();
            vectors++; if (rf_we !== e_we)         begin miscompares++; $display("FAIL rnd_we[%0d]: got %b want %b", n, rf_we, e_we); end
            vectors++; if (wb_hold !== e_hold)     begin miscompares++; $display("FAIL rnd_hold[%0d]: got %b want %b", n, wb_hold, e_hold); end
            vectors++; if (iss_stall !== e_stall)  begin miscompares++; $display("FAIL rnd_stall[%0d]: got %b want %b", n, iss_stall, e_stall); end
            vectors++; if (llu_ready !== e_ready)  begin miscompares++; $display("FAIL rnd_ready[%0d]: got %b want %b", n, llu_ready, e_ready); end
            vectors++; if (busy !== m_busy)        begin miscompares++; $display("FAIL rnd_busy[%0d]: got %h want %h", n, busy, m_busy); end
            if (e_known) begin
                vectors++; if (rf_a3 !== e_a3)  begin miscompares++; $display("FAIL rnd_a3[%0d]: got %0d want %0d", n, rf_a3, e_a3); end
                vectors++; if (rf_wd3 !== e_wd) begin miscompares++; $display("FAIL rnd_wd3[%0d]: got %h want %h", n, rf_wd3, e_wd); end
            end
            advance();
        end
        set_idle();
    endtask

    // ------------------------------------------------------------------------
    // Sequencer and watchdog
    // ------------------------------------------------------------------------
    initial begin
        set_idle();
        reset = 1'b1;
        model_clear();
        #1;
        test_reset();
        test_wb_write();
        test_scoreboard();
        test_starvation();
        test_fifo_full();
        test_x0_waw();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "simulation did not complete");
    end

endmodule
